// File: rtl/debounce_array.sv
// Multi-channel input debouncer: two-flop synchronizer, sample-tick-driven
// stability counter, edge pulses and a one-shot long-press detector per channel.
module debounce_array #(
    parameter int   CHANNELS   = 4,
    parameter int   STABLE_CNT = 100,
    parameter int   LONG_CNT   = 1000,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] noisy_in,
    output logic [CHANNELS-1:0] stable_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] long_pulse
);

    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int LW = $clog2(LONG_CNT + 1);
    localparam logic [SW-1:0] STABLE_MAX   = SW'(STABLE_CNT);
    localparam logic [LW-1:0] LONG_MAX     = LW'(LONG_CNT);
    localparam logic          ACTIVE_LEVEL = ~IDLE_LEVEL;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic          sync1_q, sync1_d;
        logic          sync2_q, sync2_d;
        logic          cand_q, cand_d;
        logic [SW-1:0] cnt_q, cnt_d;
        logic          stable_q, stable_d;
        logic [LW-1:0] long_cnt_q, long_cnt_d;
        logic          rise_q, rise_d;
        logic          fall_q, fall_d;
        logic          long_q, long_d;

        always_comb begin
            sync1_d    = noisy_in[gi];
            sync2_d    = sync1_q;
            cand_d     = cand_q;
            cnt_d      = cnt_q;
            stable_d   = stable_q;
            long_cnt_d = long_cnt_q;
            long_d     = 1'b0;

            if (sample_en) begin
                // Any disagreement restarts the stability window on the new level.
                if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q < STABLE_MAX) begin
                    cnt_d = cnt_q + SW'(1);
                    if ((cnt_d == STABLE_MAX) && (cand_q != stable_q)) begin
                        stable_d = cand_q;
                    end
                end

                // Long press counts on the registered level, so it starts the tick after commit.
                if (stable_q == ACTIVE_LEVEL) begin
                    if (long_cnt_q < LONG_MAX) begin
                        long_cnt_d = long_cnt_q + LW'(1);
                        long_d     = (long_cnt_d == LONG_MAX);
                    end
                end else begin
                    long_cnt_d = '0;
                end
            end

            rise_d = stable_d & ~stable_q;
            fall_d = ~stable_d & stable_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q    <= IDLE_LEVEL;
                sync2_q    <= IDLE_LEVEL;
                cand_q     <= IDLE_LEVEL;
                cnt_q      <= '0;
                stable_q   <= IDLE_LEVEL;
                long_cnt_q <= '0;
                rise_q     <= 1'b0;
                fall_q     <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                sync1_q    <= sync1_d;
                sync2_q    <= sync2_d;
                cand_q     <= cand_d;
                cnt_q      <= cnt_d;
                stable_q   <= stable_d;
                long_cnt_q <= long_cnt_d;
                rise_q     <= rise_d;
                fall_q     <= fall_d;
                long_q     <= long_d;
            end
        end

        assign stable_out[gi] = stable_q;
        assign rise_pulse[gi] = rise_q;
        assign fall_pulse[gi] = fall_q;
        assign long_pulse[gi] = long_q;
    end

endmodule

// File: tb/tb_debounce_array.sv
// Scoreboard bench for debounce_array: expected pulse events are queued with
// their due cycle and compared against the outputs every clock.
module tb_debounce_array;

    localparam int CH = 4;

    logic          clk;
    logic          rst_n;
    logic          sample_en;
    logic [CH-1:0] noisy_in;
    logic [CH-1:0] stable_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic [CH-1:0] long_pulse;

    typedef struct {
        int at;
        int kind;   // 0 rise, 1 fall, 2 long
        int ch;
    } ev_t;

    ev_t           sb_q[$];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          gate     = 1'b0;
    logic [CH-1:0] exp_stable = '0;

    debounce_array #(
        .CHANNELS  (CH),
        .STABLE_CNT(4),
        .LONG_CNT  (8),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .noisy_in  (noisy_in),
        .stable_out(stable_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .long_pulse(long_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: pop events due this cycle and compare every output.
    always @(posedge clk) begin
        logic [CH-1:0] er, ef, el;
        ev_t keep[$];
        #1;
        cyc++;
        er = '0;
        ef = '0;
        el = '0;
        keep.delete();
        if (!rst_n) begin
            sb_q.delete();
            exp_stable = '0;
        end
        foreach (sb_q[i]) begin
            if (sb_q[i].at <= cyc) begin
                case (sb_q[i].kind)
                    0:       er[sb_q[i].ch] = 1'b1;
                    1:       ef[sb_q[i].ch] = 1'b1;
                    default: el[sb_q[i].ch] = 1'b1;
                endcase
            end else begin
                keep.push_back(sb_q[i]);
            end
        end
        sb_q = keep;
        exp_stable = (exp_stable | er) & ~ef;

        n_checks++;
        if (stable_out !== exp_stable) begin
            n_fail++;
            $display("FAIL sb_stable cyc=%0d got=%b exp=%b", cyc, stable_out, exp_stable);
        end
        n_checks++;
        if (rise_pulse !== er) begin
            n_fail++;
            $display("FAIL sb_rise cyc=%0d got=%b exp=%b", cyc, rise_pulse, er);
        end
        n_checks++;
        if (fall_pulse !== ef) begin
            n_fail++;
            $display("FAIL sb_fall cyc=%0d got=%b exp=%b", cyc, fall_pulse, ef);
        end
        n_checks++;
        if (long_pulse !== el) begin
            n_fail++;
            $display("FAIL sb_long cyc=%0d got=%b exp=%b", cyc, long_pulse, el);
        end
        $display("cyc=%0d rst_n=%b en=%b in=%b stable=%b rise=%b fall=%b long=%b",
                 cyc, rst_n, sample_en, noisy_in, stable_out, rise_pulse, fall_pulse, long_pulse);
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_ev(input int at, input int kind, input int ch);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        e.ch   = ch;
        sb_q.push_back(e);
    endtask

    // Advance n edges; inputs may be changed by the caller on return.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            sample_en = gate ? (((cyc + 1) % 10) == 0) : 1'b1;
        end
    endtask

    task automatic test_reset();
        int t;
        noisy_in = 4'hF;
        cycles(3);
        n_checks++;
        if ({stable_out, rise_pulse, fall_pulse, long_pulse} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0000",
                     {stable_out, rise_pulse, fall_pulse, long_pulse});
        end
        rst_n = 1'b1;
        t = cyc;
        for (int c = 0; c < CH; c++) begin
            push_ev(t + 7, 0, c);
            push_ev(t + 15, 2, c);
        end
        cycles(6);
        n_checks++;
        if (stable_out !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_precommit got=%b exp=0000", stable_out);
        end
        cycles(4);
        n_checks++;
        if (stable_out !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_commit got=%b exp=1111", stable_out);
        end
        noisy_in = 4'h0;
        for (int c = 0; c < CH; c++) push_ev(cyc + 7, 1, c);
        cycles(12);
    endtask

    task automatic test_clean_press();
        int t;
        t = cyc;
        noisy_in[0] = 1'b1;
        push_ev(t + 7, 0, 0);
        push_ev(t + 15, 2, 0);
        cycles(7);
        n_checks++;
        if ((stable_out !== 4'b0001) || (rise_pulse !== 4'b0001)) begin
            n_fail++;
            $display("FAIL clean_press stable=%b rise=%b exp=0001/0001", stable_out, rise_pulse);
        end
        cycles(13);
        noisy_in[0] = 1'b0;
        push_ev(cyc + 7, 1, 0);
        cycles(12);
    endtask

    task automatic test_bounce();
        int t;
        for (int i = 0; i < 10; i++) begin
            noisy_in[1] = ~noisy_in[1];
            cycles(2);
        end
        t = cyc;
        noisy_in[1] = 1'b1;
        push_ev(t + 7, 0, 1);
        push_ev(t + 15, 2, 1);
        cycles(20);
        noisy_in[1] = 1'b0;
        push_ev(cyc + 7, 1, 1);
        cycles(12);
    endtask

    task automatic test_glitch();
        noisy_in[2] = 1'b1;
        cycles(3);
        noisy_in[2] = 1'b0;
        cycles(12);
        n_checks++;
        if (stable_out !== 4'h0) begin
            n_fail++;
            $display("FAIL glitch_stable got=%b exp=0000", stable_out);
        end
    endtask

    task automatic test_long_press();
        int t;
        t = cyc;
        noisy_in[3] = 1'b1;
        push_ev(t + 7, 0, 3);
        push_ev(t + 15, 2, 3);
        cycles(30);
        noisy_in[3] = 1'b0;
        push_ev(cyc + 7, 1, 3);
        cycles(12);
    endtask

    task automatic test_back_to_back();
        int t;
        t = cyc;
        noisy_in = 4'b0101;
        push_ev(t + 7, 0, 0);
        push_ev(t + 7, 0, 2);
        push_ev(t + 15, 2, 0);
        push_ev(t + 15, 2, 2);
        cycles(10);
        noisy_in[0] = 1'b0;
        push_ev(cyc + 7, 1, 0);
        cycles(10);
        noisy_in[2] = 1'b0;
        push_ev(cyc + 7, 1, 2);
        cycles(12);
    endtask

    task automatic test_gating_and_reset();
        int t;
        int e0;
        gate      = 1'b1;
        sample_en = (((cyc + 1) % 10) == 0);
        t = cyc;
        noisy_in[0] = 1'b1;
        e0 = t + 3;
        while ((e0 % 10) != 0) e0++;
        push_ev(e0 + 40, 0, 0);
        cycles(7);
        n_checks++;
        if (stable_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_early got=%b exp=0", stable_out[0]);
        end
        cycles(e0 + 40 - t - 7 + 10);
        n_checks++;
        if (stable_out !== 4'b0001) begin
            n_fail++;
            $display("FAIL gate_commit got=%b exp=0001", stable_out);
        end
        noisy_in[1] = 1'b1;
        cycles(15);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({stable_out, rise_pulse, fall_pulse, long_pulse} !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_async got=%h exp=0000",
                     {stable_out, rise_pulse, fall_pulse, long_pulse});
        end
        noisy_in  = 4'h0;
        gate      = 1'b0;
        sample_en = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        cycles(20);
        n_checks++;
        if (stable_out !== 4'h0) begin
            n_fail++;
            $display("FAIL midreset_after got=%b exp=0000", stable_out);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        noisy_in  = '0;
        sample_en = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_press();
        test_back_to_back();
        test_gating_and_reset();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got=%0d pending exp=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_array.md
DEBOUNCE_ARRAY -- requirements
Module: debounce_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent input channels (legal 1..32).
REQ-002 SHALL have parameter STABLE_CNT, default 100, consecutive matching samples needed to commit a new level (legal >= 1).
REQ-003 SHALL have parameter LONG_CNT, default 1000, sample ticks an active level must persist before a long-press pulse (legal >= 1).
REQ-004 SHALL have parameter IDLE_LEVEL, default 1'b0, inactive input level shared by all channels.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sample_en  input  1  sample tick; debounce and long-press logic advance only on cycles where it is 1.
REQ-008 SHALL have port noisy_in  input  CHANNELS  raw asynchronous inputs, one bit per channel.
REQ-009 SHALL have port stable_out  output  CHANNELS  debounced level per channel.
REQ-010 SHALL have port rise_pulse  output  CHANNELS  one-cycle pulse when stable_out goes 0->1.
REQ-011 SHALL have port fall_pulse  output  CHANNELS  one-cycle pulse when stable_out goes 1->0.
REQ-012 SHALL have port long_pulse  output  CHANNELS  one-cycle pulse when a channel has held the active level (~IDLE_LEVEL) for LONG_CNT sample ticks.

Function
REQ-013 SHALL pass each noisy_in bit through a two-flop synchronizer; second flop (sync) feeds all further logic.
REQ-014 SHALL keep per channel a candidate bit and a stable counter of width $clog2(STABLE_CNT+1), saturating at STABLE_CNT.
REQ-015 SHALL, on a sample_en cycle where sync != candidate, load candidate <= sync and counter <= 0.
REQ-016 SHALL, on a sample_en cycle where sync == candidate and counter < STABLE_CNT, increment counter; when it reaches STABLE_CNT and candidate != stable_out, set stable_out <= candidate on that same edge.
REQ-017 SHALL hold stable_out at its last committed value during bouncing (never forced to idle level).
REQ-018 SHALL, with sample_en tied 1, update stable_out exactly STABLE_CNT+3 clk edges after a clean input edge (2 sync, 1 candidate load, STABLE_CNT count).
REQ-019 SHALL hold all state unchanged on cycles where sample_en is 0 (synchronizer still runs every cycle).
REQ-020 SHALL register rise_pulse/fall_pulse so they are high exactly in the cycle in which stable_out first shows the new value, for one clk cycle regardless of sample_en.
REQ-021 SHALL keep per channel a long counter of width $clog2(LONG_CNT+1): on a sample_en cycle, increments while registered stable_out == ~IDLE_LEVEL and counter < LONG_CNT; cleared to 0 whenever stable_out == IDLE_LEVEL.
REQ-022 SHALL assert long_pulse for one clk cycle on the edge where long counter becomes LONG_CNT; counter then saturates, so at most one long_pulse per activation.
REQ-023 SHALL make rise_pulse only on transitions to 1 and fall_pulse only to 0, independent of IDLE_LEVEL; long_pulse follows the ~IDLE_LEVEL activation.
REQ-024 SHALL process channels fully independently; simultaneous events on several channels produce simultaneous pulses.
REQ-025 SHALL never produce rise_pulse and fall_pulse together on one channel.

Reset
REQ-026 SHALL, while rst_n=0, set synchronizer flops, candidate and stable_out to IDLE_LEVEL, all counters to 0, and rise_pulse/fall_pulse/long_pulse to 0, asynchronously.
REQ-027 SHALL generate no pulse on reset release; reset mid-count discards partial counts and any in-progress long press.

Verification (CHANNELS=4, STABLE_CNT=4, LONG_CNT=8, IDLE_LEVEL=0, sample_en=1 unless stated)
REQ-028 SHALL check reset: rst_n=0 with noisy_in=4'hF -> all outputs 0; after release and 10 cycles of 4'hF, outputs still 0 until commit.
REQ-029 SHALL check clean press: noisy_in[0] 0->1 held -> stable_out[0]=1 exactly 7 edges later, rise_pulse[0] high that one cycle, channels 1-3 unchanged.
REQ-030 SHALL check bounce/glitch: noisy_in[1] toggled every 2 cycles for 20 cycles then held 1 -> one rise_pulse 7 edges after last toggle; a 3-cycle high glitch on ch2 -> no change, no pulses.
REQ-031 SHALL check long press: ch3 held 1 for 30 cycles -> long_pulse[3] exactly 8 edges after rise_pulse[3], only once; release -> fall_pulse[3] 7 edges after input falls.
REQ-032 SHALL check sample_en gating and reset mid-operation: sample_en every 10th cycle -> commit after 4 ticks, not 4 cycles; rst_n pulsed low mid-count -> stable_out=0 immediately, no pulse after release.
